ultrasonic_seq_ctrl: RTL and testbench

- Sequencer between the AXI command decoder and the ultrasonic analog front end.
- Consumes decoded one-hot command strobes (on/off, increase/decrease, send/receive, amount) and drives the DAC drive level.
- Generates the transmit burst, opens the receive window, and measures echo time-of-flight in clock cycles.
- Results are reported back toward the AXI side as a done/timeout pulse plus a latched count.

---
 rtl/ultrasonic_seq_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ultrasonic_seq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ultrasonic_seq_ctrl : DAC level control, TX burst, RX time-of-flight  |
// | Optional macro ECHO_SYNC_EN adds a 2-flop echo synchronizer. Rev 1.0  |
// +----------------------------------------------------------------------+
module ultrasonic_seq_ctrl #(
  parameter int AMT_W        = 8,
  parameter int DAC_W        = 8,
  parameter int CNT_W        = 16,
  parameter int HALF_PER     = 25,
  parameter int BURST_PULSES = 8,
  parameter int GUARD_CYC    = 100,
  parameter int TIMEOUT      = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic             cmd_on,
  input  logic             cmd_off,
  input  logic             cmd_inc,
  input  logic             cmd_dec,
  input  logic             cmd_send,
  input  logic             cmd_receive,
  input  logic [AMT_W-1:0] cmd_amount,
  input  logic             echo_in,
  output logic [DAC_W-1:0] dac_level,
  output logic             dac_load,
  output logic             tx_out,
  output logic             rx_enable,
  output logic             busy,
  output logic             powered,
  output logic [CNT_W-1:0] tof,
  output logic             done,
  output logic             timeout
);

  localparam int SW = ((AMT_W > DAC_W) ? AMT_W : DAC_W) + 1;
  localparam logic [SW-1:0]    c_DAC_MAX   = SW'({DAC_W{1'b1}});
  localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] c_HP_LAST   = CNT_W'(HALF_PER - 1);
  localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(2 * BURST_PULSES - 1);
  localparam logic [CNT_W-1:0] c_G_LAST    = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] c_TO_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_IDLE   = 3'd1,
    S_TX     = 3'd2,
    S_GUARD  = 3'd3,
    S_LISTEN = 3'd4
  } state_t;

  state_t           r_state, w_state_nx;
  logic [DAC_W-1:0] r_dac, w_inc_val, w_dec_val;
  logic [SW-1:0]    w_sum, w_diff;
  logic [CNT_W-1:0] r_cnt, r_ph, r_half, r_tof;
  logic             r_tx, r_load, r_done, r_tmo;
  logic             w_busy, w_inc, w_dec, w_go_tx, w_go_rx, w_done, w_tmo;
  logic             w_echo, r_echo_prev, w_edge;

  // Echo edge source
`ifdef ECHO_SYNC_EN
  logic r_sync1, r_sync2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= echo_in;
      r_sync2 <= r_sync1;
    end
  end
  assign w_echo = r_sync2;
`else
  assign w_echo = echo_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_echo_prev <= 1'b0;
    else     r_echo_prev <= w_echo;
  end
  assign w_edge = w_echo & ~r_echo_prev;

  // Saturating DAC arithmetic, one bit wider than either operand
  assign w_sum     = SW'(r_dac) + SW'(cmd_amount);
  assign w_diff    = SW'(r_dac) - SW'(cmd_amount);
  assign w_inc_val = (w_sum > c_DAC_MAX) ? '1 : w_sum[DAC_W-1:0];
  assign w_dec_val = w_diff[SW-1] ? '0 : w_diff[DAC_W-1:0];

  assign w_busy = (r_state == S_TX) || (r_state == S_GUARD) || (r_state == S_LISTEN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_OFF;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_inc      = 1'b0;
    w_dec      = 1'b0;
    w_go_tx    = 1'b0;
    w_go_rx    = 1'b0;
    w_done     = 1'b0;
    w_tmo      = 1'b0;
    if (cmd_valid && cmd_off) begin
      w_state_nx = S_OFF;
    end else begin
      case (r_state)
        S_OFF: if (cmd_valid && cmd_on) w_state_nx = S_IDLE;
        S_IDLE: begin
          if (cmd_valid) begin
            w_inc = cmd_inc & ~cmd_dec;
            w_dec = cmd_dec & ~cmd_inc;
            if (cmd_send) begin
              w_state_nx = S_TX;
              w_go_tx    = 1'b1;
            end else if (cmd_receive) begin
              w_state_nx = S_LISTEN;
              w_go_rx    = 1'b1;
            end
          end
        end
        S_TX: if (r_ph == c_HP_LAST && r_half == c_HALF_LAST) w_state_nx = S_GUARD;
        S_GUARD: if (r_ph == c_G_LAST) w_state_nx = S_LISTEN;
        S_LISTEN: begin
          if (w_edge) begin
            w_done     = 1'b1;
            w_state_nx = S_IDLE;
          end else if (r_ph == c_TO_LAST) begin
            w_tmo      = 1'b1;
            w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dac  <= '0;
      r_load <= 1'b0;
      r_tof  <= '0;
      r_done <= 1'b0;
      r_tmo  <= 1'b0;
      r_cnt  <= '0;
      r_ph   <= '0;
      r_half <= '0;
      r_tx   <= 1'b0;
    end else begin
      r_load <= w_inc | w_dec;
      r_done <= w_done;
      r_tmo  <= w_tmo;
      if (w_inc)      r_dac <= w_inc_val;
      else if (w_dec) r_dac <= w_dec_val;
      if (w_done) r_tof <= r_cnt;

      if (w_go_tx || w_go_rx) begin
        r_cnt  <= '0;
        r_ph   <= '0;
        r_half <= '0;
        r_tx   <= w_go_tx;
      end else begin
        if (w_busy && r_cnt != c_CNT_MAX) r_cnt <= r_cnt + 1'b1;
        // Phase counter restarts on every state change (burst end, guard end, abort)
        if (w_state_nx != r_state) begin
          r_ph   <= '0;
          r_half <= '0;
          r_tx   <= 1'b0;
        end else if (r_state == S_TX) begin
          if (r_ph == c_HP_LAST) begin
            r_ph   <= '0;
            r_half <= r_half + 1'b1;
            r_tx   <= ~r_tx;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end else if (w_busy) begin
          r_ph <= r_ph + 1'b1;
        end
      end
    end
  end

  assign dac_level = r_dac;
  assign dac_load  = r_load;
  assign tx_out    = r_tx;
  assign rx_enable = (r_state == S_LISTEN);
  assign busy      = w_busy;
  assign powered   = (r_state != S_OFF);
  assign tof       = r_tof;
  assign done      = r_done;
  assign timeout   = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ultrasonic_seq_ctrl : directed self-checking bench for the         |
// | ultrasonic sequencer (short timing parameters). Rev 1.0               |
// +----------------------------------------------------------------------+
module tb_ultrasonic_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_on, cmd_off, cmd_inc, cmd_dec, cmd_send, cmd_receive;
  logic [7:0]  cmd_amount;
  logic        echo_in;
  logic [7:0]  dac_level;
  logic        dac_load, tx_out, rx_enable, busy, powered, done, timeout;
  logic [15:0] tof;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

`ifdef ECHO_SYNC_EN
  localparam int c_TOF  = 18;
  localparam int c_DLAT = 3;
`else
  localparam int c_TOF  = 16;
  localparam int c_DLAT = 1;
`endif

  ultrasonic_seq_ctrl #(
    .AMT_W(8), .DAC_W(8), .CNT_W(16), .HALF_PER(2), .BURST_PULSES(2),
    .GUARD_CYC(3), .TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_on(cmd_on), .cmd_off(cmd_off),
    .cmd_inc(cmd_inc), .cmd_dec(cmd_dec), .cmd_send(cmd_send), .cmd_receive(cmd_receive),
    .cmd_amount(cmd_amount), .echo_in(echo_in), .dac_level(dac_level), .dac_load(dac_load),
    .tx_out(tx_out), .rx_enable(rx_enable), .busy(busy), .powered(powered), .tof(tof),
    .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bits: {on, off, inc, dec, send, receive}
  task automatic command(input logic [5:0] bits, input logic [7:0] amt);
    cmd_valid = 1'b1;
    {cmd_on, cmd_off, cmd_inc, cmd_dec, cmd_send, cmd_receive} = bits;
    cmd_amount = amt;
    tick();
    cmd_valid = 1'b0;
    {cmd_on, cmd_off, cmd_inc, cmd_dec, cmd_send, cmd_receive} = '0;
    cmd_amount = '0;
  endtask

  localparam logic [5:0] ON = 6'b100000, OFF = 6'b010000, INC = 6'b001000;
  localparam logic [5:0] DEC = 6'b000100, SEND = 6'b000010, RECV = 6'b000001;

  initial begin
    logic [7:0] pat;
    int n;
    logic seen;
    pat = 8'b0011_0011;
    rst = 1'b1; echo_in = 1'b0; cmd_valid = 1'b0; cmd_amount = '0;
    {cmd_on, cmd_off, cmd_inc, cmd_dec, cmd_send, cmd_receive} = '0;
    tick(); tick();
    check("rst_powered", powered, 0);
    check("rst_dac", dac_level, 0);
    check("rst_tof", tof, 0);
    check("rst_outs", {tx_out, rx_enable, busy, done, timeout, dac_load}, 0);
    rst = 1'b0;
    tick();

    // Commands other than on are ignored while off
    command(INC, 8'd40);
    check("off_inc_ignored", {powered, dac_load, dac_level}, 0);
    command(ON, 8'd0);
    check("on_powered", {powered, busy}, 2'b10);

    command(INC, 8'd200);
    check("inc200", dac_level, 200);
    check("inc200_load", dac_load, 1);
    tick();
    check("load_one_cycle", dac_load, 0);
    command(INC, 8'd100);
    check("inc_sat", {dac_load, dac_level}, {1'b1, 8'd255});
    command(DEC, 8'd205);
    check("dec_to_50", dac_level, 50);
    command(DEC, 8'd80);
    check("dec_floor", {dac_load, dac_level}, {1'b1, 8'd0});
    tick();
    check("dec_load_drop", dac_load, 0);
    command(INC | DEC, 8'd9);
    check("inc_dec_both", {dac_load, dac_level}, 0);

    // Transmit burst, guard, listen, echo
    command(SEND, 8'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_pat%0d", i), {busy, tx_out}, {1'b1, pat[i]});
      if (i == 3) command(INC | SEND, 8'd7);
      else tick();
    end
    check("busy_cmd_ignored", dac_level, 0);
    check("guard0", {busy, tx_out, rx_enable}, 3'b100);
    echo_in = 1'b1;
    tick();
    check("guard_echo_ignored", {busy, done, rx_enable}, 3'b100);
    echo_in = 1'b0;
    tick(); tick();
    check("listen_entry", {busy, rx_enable}, 2'b11);
    for (int i = 0; i < 5; i++) tick();
    echo_in = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = done;
    end
    check("done_latency", n, c_DLAT);
    check("tof_echo", tof, c_TOF);
    check("echo_idle", {busy, rx_enable, powered}, 3'b001);
    tick();
    check("done_one_cycle", done, 0);
    echo_in = 1'b0;

    // Listen-only timeout
    command(RECV, 8'd0);
    n = 0;
    while (rx_enable && n < 50) begin
      check("tmo_early", timeout, 0);
      tick();
      n++;
    end
    check("rx_cycles", n, 10);
    check("timeout_pulse", {timeout, done, busy}, 3'b100);
    check("tof_kept", tof, c_TOF);
    tick();
    check("timeout_one_cycle", timeout, 0);

    // Echo already high at listen entry is not an edge
    echo_in = 1'b1;
    tick(); tick(); tick();
    command(RECV, 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | done;
    end
    check("high_entry_no_done", {seen, timeout}, 2'b01);
    echo_in = 1'b0;
    tick();

    // Abort mid-TX
    command(INC, 8'd30);
    command(SEND, 8'd0);
    tick(); tick();
    command(OFF | SEND, 8'd0);
    check("abort", {tx_out, busy, powered, done, timeout}, 0);
    check("abort_dac_held", dac_level, 30);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | done | timeout;
    end
    check("abort_no_pulse", seen, 0);
    command(SEND, 8'd0);
    check("send_while_off", {busy, powered, tx_out}, 0);
    command(ON | SEND, 8'd0);
    check("on_send_idle", {powered, busy}, 2'b10);
    command(OFF | ON | INC, 8'd5);
    check("off_beats_all", {powered, dac_level}, {1'b0, 8'd30});
    command(ON, 8'd0);

    // Sync reset during listen
    command(RECV, 8'd0);
    tick();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
    check("rst_glitch_ignored", {powered, rx_enable, dac_level}, {2'b11, 8'd30});
    echo_in = 1'b1;
    rst = 1'b1;
    tick();
    check("rst_listen", {powered, rx_enable, busy, done, timeout, tx_out}, 0);
    check("rst_listen_regs", {dac_level, tof}, 0);
    rst = 1'b0;
    echo_in = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
